// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port between ALU and LSU,
// with a registered write stage and a per-register busy scoreboard.
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            we,
    output logic [AW-1:0]   wa,
    output logic [XLEN-1:0] wdata,
    output logic [CNTW-1:0] conflict_cnt
);

    localparam int NREG = 1 << AW;

    typedef enum logic {GR_ALU, GR_LSU} grant_t;

    grant_t          last_q;
    grant_t          last_d;
    logic [NREG-1:0] busy;
    logic            alu_xfer;
    logic            lsu_xfer;
    logic            conflict;

    assign conflict = alu_valid && lsu_valid && !stall;

    always_comb begin
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        last_d    = last_q;
        if (!stall) begin
            if (alu_valid && lsu_valid) begin
                alu_ready = (last_q == GR_LSU);
                lsu_ready = (last_q == GR_ALU);
            end else begin
                alu_ready = alu_valid;
                lsu_ready = lsu_valid;
            end
        end
        if (alu_ready && alu_valid) begin
            last_d = GR_ALU;
        end else if (lsu_ready && lsu_valid) begin
            last_d = GR_LSU;
        end
    end

    assign alu_xfer = alu_valid && alu_ready;
    assign lsu_xfer = lsu_valid && lsu_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= GR_LSU;
        end else begin
            last_q <= last_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we    <= 1'b0;
            wa    <= '0;
            wdata <= '0;
        end else if (alu_xfer) begin
            we    <= (alu_rd != '0);
            wa    <= alu_rd;
            wdata <= alu_data;
        end else if (lsu_xfer) begin
            we    <= (lsu_rd != '0);
            wa    <= lsu_rd;
            wdata <= lsu_data;
        end else begin
            we    <= 1'b0;
        end
    end

    // Clear first so a same-edge issue to the same register keeps it busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            if (we && (wa != '0)) begin
                busy[wa] <= 1'b0;
            end
            if (issue_valid && (issue_rd != '0)) begin
                busy[issue_rd] <= 1'b1;
            end
        end
    end

    assign rs1_busy = (ra1 != '0) && busy[ra1];
    assign rs2_busy = (ra2 != '0) && busy[ra2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if (conflict && (conflict_cnt != {CNTW{1'b1}})) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule
